// File: rtl/aluseq_pkg.sv
// Shared opcodes, nibble-mode constants, state encoding and output decode for aluseq_ctrl.
// Optional divide sequence is enabled by defining ALUSEQ_DIV_EN.
package aluseq_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_DIV  = 3'b110;
    localparam logic [2:0] OP_OUT  = 3'b111;

    localparam logic [1:0] HS_HOLD = 2'b00;
    localparam logic [1:0] HS_SHR  = 2'b01;
    localparam logic [1:0] HS_SHL  = 2'b10;
    localparam logic [1:0] HS_LOAD = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LDH,
        S_XFER,
        S_CLRH,
        S_ALU,
        S_MOP,
        S_MSH,
`ifdef ALUSEQ_DIV_EN
        S_DSH,
        S_DOP,
`endif
        S_OUT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic       clr;
        logic       ah_reset;
        logic       ah_inen;
        logic [1:0] hs;
        logic [1:0] ls;
        logic       s_add;
        logic       s_sub;
        logic       s_and;
        logic       s_mul;
        logic       s_div;
        logic       acc_oen;
    } ctl_t;

    // Datapath control word for the state about to become current.
    function automatic ctl_t ctl_decode(state_t st, logic [2:0] op);
        ctl_t c;
        c = '0;
        case (st)
            S_LDH: begin
                c.ah_inen = 1'b1;
                c.hs      = HS_LOAD;
            end
            S_XFER: c.ls = HS_LOAD;
            S_CLRH: c.ah_reset = 1'b1;
            S_ALU: begin
                c.hs    = HS_LOAD;
                c.s_add = (op == OP_ADD);
                c.s_sub = (op == OP_SUB);
                c.s_and = (op == OP_AND);
            end
            S_MOP: begin
                c.s_mul = 1'b1;
                c.hs    = HS_LOAD;
            end
            S_MSH: begin
                c.hs = HS_SHR;
                c.ls = HS_SHR;
            end
`ifdef ALUSEQ_DIV_EN
            S_DSH: begin
                c.hs = HS_SHL;
                c.ls = HS_SHL;
            end
            S_DOP: begin
                c.s_div = 1'b1;
                c.hs    = HS_LOAD;
            end
`endif
            S_OUT: c.acc_oen = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aluseq_ctrl_iter.sv
// Iteration counter for the MUL/DIV loops; cleared by the sequencer and stepped once per loop pass.
module aluseq_iter #(
    parameter int ITER = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam int W = $clog2(ITER) + 1;

    logic [W-1:0] it;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            it <= '0;
        end else if (clr) begin
            it <= '0;
        end else if (inc) begin
            it <= it + 1'b1;
        end
    end

    assign last = (it == W'(ITER - 1));

endmodule

// File: rtl/aluseq_ctrl.sv
// Micro-sequencer driving the 4-bit accumulator/ALU datapath one opcode per start/done handshake.
// Define ALUSEQ_DIV_EN to build the restoring-divide sequence; otherwise DIV completes with err.
module aluseq_ctrl
    import aluseq_pkg::*;
#(
    parameter int ITER = 4
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       sign_flag,
    input  logic       zero_flag,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] flags,
    output logic       clr,
    output logic       ah_reset,
    output logic       ah_inen,
    output logic [1:0] hs,
    output logic [1:0] ls,
    output logic       s_add,
    output logic       s_sub,
    output logic       s_and,
    output logic       s_mul,
    output logic       s_div,
    output logic       acc_oen
);

    state_t     state;
    state_t     nxt;
    logic [2:0] op_q;
    ctl_t       ctl_q;
    logic       accept;
    logic       it_clr;
    logic       it_inc;
    logic       it_last;

    assign accept = (state == S_IDLE) && !busy && start;
    assign it_clr = (state == S_CLRH);
`ifdef ALUSEQ_DIV_EN
    assign it_inc = (state == S_MSH) || (state == S_DOP);
`else
    assign it_inc = (state == S_MSH);
`endif

    aluseq_iter #(.ITER(ITER)) u_iter (
        .clk   (clk),
        .clr_n (clr_n),
        .clr   (it_clr),
        .inc   (it_inc),
        .last  (it_last)
    );

    // The accept edge only latches the opcode; dispatch happens from IDLE on the following edge.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: begin
                if (busy) begin
                    case (op_q)
                        OP_NOP:                 nxt = S_DONE;
                        OP_LOAD, OP_MUL:        nxt = S_LDH;
`ifdef ALUSEQ_DIV_EN
                        OP_DIV:                 nxt = S_LDH;
`else
                        OP_DIV:                 nxt = S_DONE;
`endif
                        OP_ADD, OP_SUB, OP_AND: nxt = S_ALU;
                        OP_OUT:                 nxt = S_OUT;
                        default:                nxt = S_DONE;
                    endcase
                end
            end
            S_LDH:  nxt = (op_q == OP_LOAD) ? S_DONE : S_XFER;
            S_XFER: nxt = S_CLRH;
`ifdef ALUSEQ_DIV_EN
            S_CLRH: nxt = (op_q == OP_DIV) ? S_DSH : S_MOP;
            S_DSH:  nxt = S_DOP;
            S_DOP:  nxt = it_last ? S_DONE : S_DSH;
`else
            S_CLRH: nxt = S_MOP;
`endif
            S_ALU:  nxt = S_DONE;
            S_MOP:  nxt = S_MSH;
            S_MSH:  nxt = it_last ? S_DONE : S_MOP;
            S_OUT:  nxt = S_DONE;
            S_DONE: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state     <= S_IDLE;
            op_q      <= OP_NOP;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            flags     <= '0;
            ctl_q     <= '0;
            ctl_q.clr <= 1'b1;
        end else begin
            state <= nxt;
            if (accept) begin
                op_q <= op;
                busy <= 1'b1;
            end else if (state == S_DONE) begin
                busy <= 1'b0;
            end
            done <= (nxt == S_DONE);
`ifdef ALUSEQ_DIV_EN
            err <= 1'b0;
`else
            err <= (nxt == S_DONE) && (op_q == OP_DIV);
`endif
            if (nxt == S_DONE) begin
                flags <= {sign_flag, zero_flag};
            end
            ctl_q <= ctl_decode(nxt, op_q);
        end
    end

    assign clr      = ctl_q.clr;
    assign ah_reset = ctl_q.ah_reset;
    assign ah_inen  = ctl_q.ah_inen;
    assign hs       = ctl_q.hs;
    assign ls       = ctl_q.ls;
    assign s_add    = ctl_q.s_add;
    assign s_sub    = ctl_q.s_sub;
    assign s_and    = ctl_q.s_and;
    assign s_mul    = ctl_q.s_mul;
`ifdef ALUSEQ_DIV_EN
    assign s_div    = ctl_q.s_div;
`else
    assign s_div    = 1'b0;
`endif
    assign acc_oen  = ctl_q.acc_oen;

endmodule

// File: tb/tb_aluseq_ctrl.sv
// Self-checking bench for aluseq_ctrl: vector table with per-cycle control checks and a done scoreboard.
module tb_aluseq_ctrl;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic       sign_flag = 1'b0;
    logic       zero_flag = 1'b0;
    logic       busy, done, err, clr, ah_reset, ah_inen;
    logic       s_add, s_sub, s_and, s_mul, s_div, acc_oen;
    logic [1:0] flags, hs, ls;

    aluseq_ctrl #(.ITER(4)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .op(op),
        .sign_flag(sign_flag), .zero_flag(zero_flag),
        .busy(busy), .done(done), .err(err), .flags(flags),
        .clr(clr), .ah_reset(ah_reset), .ah_inen(ah_inen), .hs(hs), .ls(ls),
        .s_add(s_add), .s_sub(s_sub), .s_and(s_and), .s_mul(s_mul), .s_div(s_div),
        .acc_oen(acc_oen)
    );

    always #5 clk = ~clk;

    // {clr, ah_reset, ah_inen, hs, ls, add, sub, and, mul, div, oen}
    logic [12:0] ctl_w;
    assign ctl_w = {clr, ah_reset, ah_inen, hs, ls, s_add, s_sub, s_and, s_mul, s_div, acc_oen};

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [12:0] mk(input logic ahr, input logic ahin, input logic [1:0] h,
                                       input logic [1:0] l, input logic [4:0] sel, input logic oen);
        return {1'b0, ahr, ahin, h, l, sel, oen};
    endfunction

    localparam logic [12:0] C_LDH  = {1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 5'b00000, 1'b0};
    localparam logic [12:0] C_RST  = 13'h1000;

    // Expected per-cycle control words between accept and done (exclusive of DONE).
    logic [12:0] exp_seq [0:31];
    int          exp_n;

    task automatic build_seq(input logic [2:0] o);
        exp_n = 0;
        case (o)
            3'b001: begin exp_seq[0] = C_LDH; exp_n = 1; end
            3'b010: begin exp_seq[0] = mk(0, 0, 2'b11, 2'b00, 5'b10000, 0); exp_n = 1; end
            3'b011: begin exp_seq[0] = mk(0, 0, 2'b11, 2'b00, 5'b01000, 0); exp_n = 1; end
            3'b100: begin exp_seq[0] = mk(0, 0, 2'b11, 2'b00, 5'b00100, 0); exp_n = 1; end
            3'b111: begin exp_seq[0] = mk(0, 0, 2'b00, 2'b00, 5'b00000, 1); exp_n = 1; end
            3'b101, 3'b110: begin
`ifndef ALUSEQ_DIV_EN
                if (o == 3'b110) return;
`endif
                exp_seq[0] = C_LDH;
                exp_seq[1] = mk(0, 0, 2'b00, 2'b11, 5'b00000, 0);
                exp_seq[2] = mk(1, 0, 2'b00, 2'b00, 5'b00000, 0);
                for (int i = 0; i < 4; i++) begin
                    if (o == 3'b101) begin
                        exp_seq[3 + 2*i] = mk(0, 0, 2'b11, 2'b00, 5'b00010, 0);
                        exp_seq[4 + 2*i] = mk(0, 0, 2'b01, 2'b01, 5'b00000, 0);
                    end else begin
                        exp_seq[3 + 2*i] = mk(0, 0, 2'b10, 2'b10, 5'b00000, 0);
                        exp_seq[4 + 2*i] = mk(0, 0, 2'b11, 2'b00, 5'b00001, 0);
                    end
                end
                exp_n = 11;
            end
            default: exp_n = 0;
        endcase
    endtask

    typedef struct {
        int         acc_cyc;
        int         lat;
        logic       err;
        logic [1:0] flags;
    } sb_t;
    sb_t sb [$];

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("done_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                check("done_err", 32'(err), 32'(e.err));
                check("done_flags", 32'(flags), 32'(e.flags));
            end
        end
    end

    typedef struct {
        logic [2:0] op;
        logic       sgn;
        logic       zro;
        int         poke_k;
        logic [2:0] poke_op;
        int         lat;
        logic       err;
        logic [1:0] flags;
    } vec_t;

    vec_t vecs [0:9];

    task automatic run_vec(input vec_t v);
        sb_t e;
        build_seq(v.op);
        @(negedge clk);
        start = 1'b1; op = v.op; sign_flag = v.sgn; zero_flag = v.zro;
        @(posedge clk);
        e.acc_cyc = cyc + 1;
        e.lat = v.lat; e.err = v.err; e.flags = v.flags;
        sb.push_back(e);
        #1;
        check("accept_busy", 32'({busy, ctl_w}), 32'({1'b1, 13'h0}));
        for (int k = 1; k <= v.lat + 1; k++) begin
            @(negedge clk);
            if (k == v.poke_k) begin
                start = 1'b1; op = v.poke_op;
            end else begin
                start = 1'b0; op = 3'($urandom_range(0, 7));
            end
            @(posedge clk);
            #1;
            if (k < v.lat) begin
                check("seq_ctl", 32'({busy, ctl_w}), 32'({1'b1, exp_seq[k-1]}));
            end else if (k == v.lat) begin
                check("done_cycle_ctl", 32'({busy, done, ctl_w}), 32'({2'b11, 13'h0}));
            end else begin
                check("idle_after_done", 32'({busy, done, ctl_w}), 32'd0);
                check("flags_held", 32'(flags), 32'(v.flags));
            end
        end
        start = 1'b0;
        check("done_seen", 32'(sb.size()), 32'd0);
    endtask

    initial begin
`ifdef ALUSEQ_DIV_EN
        localparam int  DIV_LAT = 12;
        localparam logic DIV_ERR = 1'b0;
`else
        localparam int  DIV_LAT = 1;
        localparam logic DIV_ERR = 1'b1;
`endif
        vecs[0] = '{3'b000, 1'b0, 1'b0, 0, 3'b000, 1,  1'b0,    2'b00};
        vecs[1] = '{3'b001, 1'b1, 1'b0, 0, 3'b000, 2,  1'b0,    2'b10};
        vecs[2] = '{3'b010, 1'b0, 1'b1, 0, 3'b000, 2,  1'b0,    2'b01};
        vecs[3] = '{3'b011, 1'b1, 1'b1, 0, 3'b000, 2,  1'b0,    2'b11};
        vecs[4] = '{3'b100, 1'b0, 1'b1, 0, 3'b000, 2,  1'b0,    2'b01};
        vecs[5] = '{3'b111, 1'b1, 1'b0, 0, 3'b000, 2,  1'b0,    2'b10};
        vecs[6] = '{3'b101, 1'b0, 1'b0, 7, 3'b010, 12, 1'b0,    2'b00};
        vecs[7] = '{3'b110, 1'b1, 1'b0, 0, 3'b000, DIV_LAT, DIV_ERR, 2'b10};
        vecs[8] = '{3'b001, 1'b0, 1'b1, 3, 3'b010, 2,  1'b0,    2'b01};
        vecs[9] = '{3'b010, 1'b1, 1'b1, 1, 3'b101, 2,  1'b0,    2'b11};

        clr_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", 32'(ctl_w), 32'(C_RST));
        check("reset_status", 32'({busy, done, err, flags}), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_ctl", 32'({busy, ctl_w}), 32'd0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Abort a MUL with reset in its sixth cycle: no done, controls back to reset values.
        build_seq(3'b101);
        @(negedge clk);
        start = 1'b1; op = 3'b101; sign_flag = 1'b1; zero_flag = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
            #1;
            check("abort_pre_ctl", 32'(ctl_w), 32'(exp_seq[k-1]));
        end
        @(negedge clk);
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ctl", 32'(ctl_w), 32'(C_RST));
        check("abort_status", 32'({busy, done, flags}), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_release", 32'({busy, done, ctl_w}), 32'd0);
        run_vec('{3'b000, 1'b0, 1'b1, 0, 3'b000, 1, 1'b0, 2'b01});

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
